lock_acq_sequencer: RTL and testbench

- Sequences OPO lock acquisition around the lock-in datapath: sweeps an actuator offset until the demodulated X quadrature crosses a threshold, then engages the PID.
- Confirms lock over a settle window, monitors for lock loss, and re-sweeps automatically.
- Sits after ch_processing and consumes x_out plus a per-average valid strobe from the averaging timer. Drives the actuator offset and the PID enable.

---
 rtl/lock_acq_if.sv | 38 +++
 rtl/lock_acq_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lock_acq_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lock_acq_if.sv
// Bus between the lock-acquisition sequencer and the control/datapath side:
// sample stream, software settings and registered status outputs.
interface lock_acq_if #(
   parameter int unsigned CART_LENGTH   = 24,
   parameter int unsigned DAC_LENGTH    = 14,
   parameter int unsigned CNT_LENGTH    = 16,
   parameter int unsigned RELOCK_LENGTH = 16
);
   logic                          start;
   logic                          abort;
   logic signed [CART_LENGTH-1:0] x_in;
   logic                          x_valid;
   logic        [CART_LENGTH-2:0] lock_thresh;
   logic        [CART_LENGTH-2:0] unlock_thresh;
   logic        [DAC_LENGTH-1:0]  sweep_min;
   logic        [DAC_LENGTH-1:0]  sweep_max;
   logic        [DAC_LENGTH-1:0]  sweep_step;
   logic        [CNT_LENGTH-1:0]  settle_samples;
   logic        [CNT_LENGTH-1:0]  loss_samples;
   logic        [DAC_LENGTH-1:0]  sweep_out;
   logic                          pid_enable;
   logic                          locked;
   logic                          fault;
   logic        [2:0]             state_out;
   logic      [RELOCK_LENGTH-1:0] relock_count;

   modport master (
      output start, abort, x_in, x_valid, lock_thresh, unlock_thresh,
             sweep_min, sweep_max, sweep_step, settle_samples, loss_samples,
      input  sweep_out, pid_enable, locked, fault, state_out, relock_count
   );

   modport slave (
      input  start, abort, x_in, x_valid, lock_thresh, unlock_thresh,
             sweep_min, sweep_max, sweep_step, settle_samples, loss_samples,
      output sweep_out, pid_enable, locked, fault, state_out, relock_count
   );
endinterface

// File: rtl/lock_acq_sequencer.sv
// OPO lock acquisition: sweep the actuator offset until |X| crosses a threshold,
// engage the PID, confirm lock over a settle window and re-sweep on lock loss.
module lock_acq_sequencer #(
   parameter int unsigned CART_LENGTH   = 24,
   parameter int unsigned DAC_LENGTH    = 14,
   parameter int unsigned CNT_LENGTH    = 16,
   parameter int unsigned MAX_PASSES    = 4,
   parameter int unsigned RELOCK_LENGTH = 16
) (
   input logic        clk,
   input logic        rst,
   lock_acq_if.slave  bus
);

   localparam int unsigned MagW  = CART_LENGTH - 1;
   localparam int unsigned PassW = $clog2(MAX_PASSES + 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSweep  = 3'd1,
      StSettle = 3'd2,
      StLocked = 3'd3,
      StFault  = 3'd4
   } state_e;

   state_e                   state_q;
   logic [DAC_LENGTH-1:0]    sweep_q;
   logic                     pid_q;
   logic                     locked_q;
   logic                     fault_q;
   logic [RELOCK_LENGTH-1:0] relock_q;
   logic [PassW-1:0]         pass_q;
   logic [CNT_LENGTH-1:0]    good_q;
   logic [CNT_LENGTH-1:0]    bad_q;

   logic [CART_LENGTH-1:0] x_neg;
   logic [MagW-1:0]        mag;
   logic [DAC_LENGTH-1:0]  step_eff;
   logic [DAC_LENGTH:0]    sweep_sum;
   logic                   wrap;
   logic [DAC_LENGTH-1:0]  adv_sweep;
   logic [PassW-1:0]       pass_inc;
   logic                   pass_exhausted;
   logic                   start_ok;
   logic [CNT_LENGTH:0]    good_inc;
   logic [CNT_LENGTH:0]    bad_inc;
   logic                   settle_done;
   logic                   loss_done;

   always_comb begin
      x_neg = -bus.x_in;
      if (!bus.x_in[CART_LENGTH-1]) begin
         mag = bus.x_in[MagW-1:0];
      end else if (x_neg[CART_LENGTH-1]) begin
         // Only the most negative input stays negative after negation.
         mag = '1;
      end else begin
         mag = x_neg[MagW-1:0];
      end
   end

   always_comb begin
      step_eff       = (bus.sweep_step == '0) ? DAC_LENGTH'(1) : bus.sweep_step;
      sweep_sum      = {1'b0, sweep_q} + {1'b0, step_eff};
      wrap           = sweep_sum > {1'b0, bus.sweep_max};
      adv_sweep      = wrap ? bus.sweep_min : sweep_sum[DAC_LENGTH-1:0];
      pass_inc       = pass_q + PassW'(1);
      pass_exhausted = wrap && (pass_inc >= PassW'(MAX_PASSES));
      start_ok       = bus.sweep_min <= bus.sweep_max;
      good_inc       = {1'b0, good_q} + (CNT_LENGTH + 1)'(1);
      bad_inc        = {1'b0, bad_q} + (CNT_LENGTH + 1)'(1);
      // A zero window behaves like one sample.
      settle_done    = good_inc >= {1'b0, bus.settle_samples};
      loss_done      = bad_inc >= {1'b0, bus.loss_samples};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sweep_q  <= '0;
         pid_q    <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         relock_q <= '0;
         pass_q   <= '0;
         good_q   <= '0;
         bad_q    <= '0;
      end else if (bus.abort) begin
         state_q  <= StIdle;
         pid_q    <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StFault: begin
               if (bus.start) begin
                  if (start_ok) begin
                     state_q <= StSweep;
                     sweep_q <= bus.sweep_min;
                     pass_q  <= '0;
                     fault_q <= 1'b0;
                  end else begin
                     state_q <= StFault;
                     fault_q <= 1'b1;
                  end
               end
            end
            StSweep: begin
               if (bus.x_valid) begin
                  if (mag >= bus.lock_thresh) begin
                     state_q <= StSettle;
                     pid_q   <= 1'b1;
                     good_q  <= '0;
                  end else begin
                     sweep_q <= adv_sweep;
                     if (wrap) pass_q <= pass_inc;
                     if (pass_exhausted) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                     end
                  end
               end
            end
            StSettle: begin
               if (bus.x_valid) begin
                  if (mag >= bus.unlock_thresh) begin
                     good_q <= good_inc[CNT_LENGTH-1:0];
                     if (settle_done) begin
                        state_q  <= StLocked;
                        locked_q <= 1'b1;
                        bad_q    <= '0;
                     end
                  end else begin
                     // Settle failure resumes the sweep where it left off.
                     state_q <= StSweep;
                     pid_q   <= 1'b0;
                     sweep_q <= adv_sweep;
                     if (wrap) pass_q <= pass_inc;
                     if (pass_exhausted) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                     end
                  end
               end
            end
            StLocked: begin
               if (bus.x_valid) begin
                  if (mag < bus.unlock_thresh) begin
                     bad_q <= bad_inc[CNT_LENGTH-1:0];
                     if (loss_done) begin
                        state_q  <= StSweep;
                        sweep_q  <= bus.sweep_min;
                        pass_q   <= '0;
                        locked_q <= 1'b0;
                        pid_q    <= 1'b0;
                        bad_q    <= '0;
                        if (relock_q != '1) relock_q <= relock_q + RELOCK_LENGTH'(1);
                     end
                  end else begin
                     bad_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               pid_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sweep_out    = sweep_q;
   assign bus.pid_enable   = pid_q;
   assign bus.locked       = locked_q;
   assign bus.fault        = fault_q;
   assign bus.state_out    = state_q;
   assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_lock_acq_sequencer.sv
// Directed bench for lock_acq_sequencer: sweep/wrap/fault, detect, settle,
// lock loss, magnitude saturation, zero step, abort priority and async reset.
module tb_lock_acq_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   lock_acq_if #(
      .CART_LENGTH(24), .DAC_LENGTH(14), .CNT_LENGTH(16), .RELOCK_LENGTH(16)
   ) bus ();

   lock_acq_sequencer #(
      .CART_LENGTH(24), .DAC_LENGTH(14), .CNT_LENGTH(16),
      .MAX_PASSES(4), .RELOCK_LENGTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [23:0] x);
      @(negedge clk);
      bus.x_in    = x;
      bus.x_valid = 1'b1;
      @(negedge clk);
      bus.x_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   initial begin
      bus.start          = 1'b0;
      bus.abort          = 1'b0;
      bus.x_in           = '0;
      bus.x_valid        = 1'b0;
      bus.lock_thresh    = 23'd1000;
      bus.unlock_thresh  = 23'd500;
      bus.sweep_min      = 14'd100;
      bus.sweep_max      = 14'd130;
      bus.sweep_step     = 14'd10;
      bus.settle_samples = 16'd5;
      bus.loss_samples   = 16'd3;

      repeat (3) @(negedge clk);
      check("rst_state", bus.state_out, 0);
      check("rst_sweep", bus.sweep_out, 0);
      check("rst_flags", {bus.pid_enable, bus.locked, bus.fault}, 0);
      check("rst_relock", bus.relock_count, 0);
      rst = 1'b0;

      // Sweep with no signal: 100,110,120,130 wrapping, FAULT after 4 passes
      pulse_start();
      check("start_state", bus.state_out, 1);
      check("start_sweep", bus.sweep_out, 100);
      for (int i = 1; i <= 15; i++) begin
         strobe(24'd0);
         check($sformatf("sweep_seq%0d", i), bus.sweep_out, 100 + 10 * (i % 4));
      end
      check("pre_fault_state", bus.state_out, 1);
      strobe(24'd0);
      check("fault_state", bus.state_out, 4);
      check("fault_flag", bus.fault, 1);

      // Restart from FAULT, detect on 3rd strobe
      pulse_start();
      check("refault_start_state", bus.state_out, 1);
      check("refault_clear", bus.fault, 0);
      strobe(24'd0);
      strobe(24'd0);
      strobe(24'd1500);
      check("detect_state", bus.state_out, 2);
      check("detect_sweep", bus.sweep_out, 120);
      check("detect_pid", bus.pid_enable, 1);

      // Settle: five good samples of -800
      for (int i = 1; i <= 4; i++) begin
         strobe(-24'sd800);
         check($sformatf("settle_wait%0d", i), {bus.state_out, bus.locked}, {3'd2, 1'b0});
      end
      strobe(-24'sd800);
      check("lock_state", bus.state_out, 3);
      check("lock_flags", {bus.pid_enable, bus.locked}, 2'b11);

      // Lock loss with a good sample in the middle
      strobe(24'd100);
      strobe(24'd100);
      strobe(24'd900);
      check("hold_after_good", {bus.state_out, bus.locked}, {3'd3, 1'b1});
      strobe(24'd100);
      strobe(24'd100);
      check("hold_bad2", {bus.state_out, bus.locked}, {3'd3, 1'b1});
      strobe(24'd100);
      check("loss_state", bus.state_out, 1);
      check("loss_sweep", bus.sweep_out, 100);
      check("loss_relock", bus.relock_count, 1);
      check("loss_flags", {bus.pid_enable, bus.locked}, 2'b00);

      // Settle failure on the 3rd sample advances the sweep to 130
      strobe(24'd0);
      strobe(24'd0);
      strobe(24'd1500);
      check("redetect_state", bus.state_out, 2);
      strobe(-24'sd800);
      strobe(-24'sd800);
      strobe(24'd300);
      check("settle_fail_state", bus.state_out, 1);
      check("settle_fail_sweep", bus.sweep_out, 130);
      check("settle_fail_pid", bus.pid_enable, 0);

      // Most negative X saturates and meets the largest threshold
      bus.lock_thresh = 23'h7fffff;
      strobe(24'h800000);
      check("sat_detect_state", bus.state_out, 2);
      check("sat_detect_sweep", bus.sweep_out, 130);
      pulse_abort();
      check("abort_settle_state", bus.state_out, 0);
      check("abort_settle_hold", bus.sweep_out, 130);

      // Zero step behaves as one
      bus.lock_thresh = 23'd1000;
      bus.sweep_min   = 14'd5;
      bus.sweep_max   = 14'd100;
      bus.sweep_step  = 14'd0;
      pulse_start();
      strobe(24'd0);
      check("step0_a", bus.sweep_out, 6);
      strobe(24'd0);
      check("step0_b", bus.sweep_out, 7);

      // Abort beats start and x_valid while locked
      bus.settle_samples = 16'd1;
      strobe(24'd1500);
      strobe(-24'sd800);
      check("lock1_state", bus.state_out, 3);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      bus.x_valid = 1'b1;
      bus.x_in    = 24'd0;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.x_valid = 1'b0;
      check("abort_state", bus.state_out, 0);
      check("abort_flags", {bus.pid_enable, bus.locked, bus.fault}, 0);
      check("abort_hold", bus.sweep_out, 7);

      // Inverted bounds go straight to FAULT
      bus.sweep_min = 14'd200;
      pulse_start();
      check("badbounds_state", bus.state_out, 4);
      check("badbounds_fault", bus.fault, 1);
      pulse_abort();
      check("fault_abort", {bus.state_out, bus.fault}, {3'd0, 1'b0});

      // Asynchronous reset mid-sweep
      bus.sweep_min  = 14'd100;
      bus.sweep_max  = 14'd130;
      bus.sweep_step = 14'd10;
      pulse_start();
      strobe(24'd0);
      check("pre_rst_sweep", bus.sweep_out, 110);
      #2 rst = 1'b1;
      #1;
      check("arst_state", bus.state_out, 0);
      check("arst_sweep", bus.sweep_out, 0);
      check("arst_relock", bus.relock_count, 0);
      check("arst_flags", {bus.pid_enable, bus.locked, bus.fault}, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
